// File: rtl/nn_fifo_arbiter_if.sv
// Bus bundle between the NN FIFO arbiter and its neighbours: wishbone slave
// side, NN core consumer side, and the strobes to the 8-deep input FIFO.
// Optional watermark signals exist only when NN_FIFO_WATERMARK_EN is defined.
interface nn_fifo_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              rd_req_i;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              flush_i;
    logic              fifo_ce_o;
    logic              fifo_we_o;
    logic              fifo_rst_o;
    logic [DATA_W-1:0] fifo_wdata_o;
    logic [DATA_W-1:0] fifo_rdata_i;
`ifdef NN_FIFO_WATERMARK_EN
    logic              almost_full_o;
    logic [CNT_W-1:0]  level_o;
`endif

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
        output wb_dat_o, wb_ack_o,
        input  rd_req_i,
        output rd_valid_o, rd_data_o,
        input  flush_i,
        output fifo_ce_o, fifo_we_o, fifo_rst_o, fifo_wdata_o,
        input  fifo_rdata_i
`ifdef NN_FIFO_WATERMARK_EN
        , output almost_full_o, level_o
`endif
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o,
        output rd_req_i,
        input  rd_valid_o, rd_data_o,
        output flush_i,
        input  fifo_ce_o, fifo_we_o, fifo_rst_o, fifo_wdata_o,
        output fifo_rdata_i
`ifdef NN_FIFO_WATERMARK_EN
        , input almost_full_o, level_o
`endif
    );
endinterface

// File: rtl/nn_fifo_arbiter.sv
// Arbiter in front of the NN datapath input FIFO. The FIFO has one (ce, we)
// pair, so writes from wishbone and pops from the NN core are serialised
// here, round-robin when both are ready, with at least two cycles between
// FIFO operations. This block owns the occupancy count; the FIFO's own
// count/full outputs are not trusted.
// Optional: define NN_FIFO_WATERMARK_EN for almost_full_o / level_o and
// almost_full reported in status bit 8.
//
// state   | meaning
// IDLE    | waiting; arbitrate flush > status > write/read
// WR      | FIFO write strobe, wishbone ack
// RD      | FIFO read strobe
// RD_DATA | FIFO output settling; word captured and delivered at end
// STAT    | wishbone status ack with count
// FLUSH   | FIFO reset pulse, count cleared
module nn_fifo_arbiter #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 4
`ifdef NN_FIFO_WATERMARK_EN
    , parameter int HI_MARK = 6
`endif
) (
    input  logic              clk,
    input  logic              rst,
    nn_fifo_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, WR, RD, RD_DATA, STAT, FLUSH
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic             G_READ  = 1'b0;
    localparam logic             G_WRITE = 1'b1;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              last_grant;
    logic              wb_wr, wb_rd, wr_ok, rd_ok;
    logic [DATA_W-1:0] stat_word;

    // Request decode and status word assembly
    always_comb begin
        wb_wr     = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
        wb_rd     = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_we_i;
        wr_ok     = wb_wr & (count < DEPTH_C);
        rd_ok     = bus.rd_req_i & (count != '0);
        stat_word = DATA_W'(count);
`ifdef NN_FIFO_WATERMARK_EN
        stat_word[8] = bus.almost_full_o;
`endif
    end

    // Sequencer: outputs are set on the grant edge so every strobe is a
    // registered single-cycle pulse during the corresponding state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            last_grant       <= G_READ;
            bus.wb_dat_o     <= '0;
            bus.wb_ack_o     <= 1'b0;
            bus.rd_valid_o   <= 1'b0;
            bus.rd_data_o    <= '0;
            bus.fifo_ce_o    <= 1'b0;
            bus.fifo_we_o    <= 1'b0;
            bus.fifo_rst_o   <= 1'b0;
            bus.fifo_wdata_o <= '0;
        end else begin
            bus.wb_ack_o   <= 1'b0;
            bus.rd_valid_o <= 1'b0;
            bus.fifo_ce_o  <= 1'b0;
            bus.fifo_we_o  <= 1'b0;
            bus.fifo_rst_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush_i) begin
                        state          <= FLUSH;
                        bus.fifo_rst_o <= 1'b1;
                        count          <= '0;
                        last_grant     <= G_READ;
                    end else if (wb_rd) begin
                        state        <= STAT;
                        bus.wb_ack_o <= 1'b1;
                        bus.wb_dat_o <= stat_word;
                    end else if (wr_ok && (!rd_ok || last_grant == G_READ)) begin
                        state            <= WR;
                        bus.fifo_ce_o    <= 1'b1;
                        bus.fifo_we_o    <= 1'b1;
                        bus.fifo_wdata_o <= bus.wb_dat_i;
                        bus.wb_ack_o     <= 1'b1;
                        count            <= count + CNT_W'(1);
                        last_grant       <= G_WRITE;
                    end else if (rd_ok) begin
                        state         <= RD;
                        bus.fifo_ce_o <= 1'b1;
                        count         <= count - CNT_W'(1);
                        last_grant    <= G_READ;
                    end
                end
                RD:      state <= RD_DATA;
                // FIFO data_o has updated by now; deliver regardless of rd_req_i
                RD_DATA: begin
                    state          <= IDLE;
                    bus.rd_valid_o <= 1'b1;
                    bus.rd_data_o  <= bus.fifo_rdata_i;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NN_FIFO_WATERMARK_EN
    // Watermark flag trails count by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.almost_full_o <= 1'b0;
        else     bus.almost_full_o <= (count >= CNT_W'(HI_MARK));
    end

    assign bus.level_o = count;
`endif

endmodule
